// File: rtl/pipeline_pkg.sv
// Shared constants for the pipeline result collector: default widths, pipeline depth
// and occupancy counter width.
package pipeline_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int DEPTH_DEF    = 8;
  localparam int PIPE_DEPTH_C = 3;
  localparam int CNT_W        = $clog2(DEPTH_DEF) + 1;

endpackage

// File: rtl/result_fifo_mem.sv
// Storage array for the result collector: one synchronous write port and an
// asynchronous read port addressed by the read pointer.
module result_fifo_mem
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [DATA_W-1:0]        o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write port; the array holds data only, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pipeline_result_collector.sv
// Collects results from the global-stall pipeline into a FIFO, drives stall as back-pressure
// and discards in-flight results after a flush. Optional counters: PIPELINE_COLLECTOR_STATS_EN.
module pipeline_result_collector
  import pipeline_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int PIPE_DEPTH = PIPE_DEPTH_C
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [DATA_W-1:0]      i_pipe_data,
  input  logic                   i_pipe_valid,
  input  logic                   i_flush,
  output logic                   o_stall,
  output logic [DATA_W-1:0]      o_m_data,
  output logic                   o_m_valid,
  input  logic                   i_m_ready,
  output logic [$clog2(DEPTH):0] o_count,
`ifdef PIPELINE_COLLECTOR_STATS_EN
  output logic [31:0]            o_stat_accepted,
  output logic [15:0]            o_stat_dropped,
  output logic [31:0]            o_stat_stall_cycles,
`endif
  output logic                   o_overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int SKID = PIPE_DEPTH + 1;
  localparam int DRW  = $clog2(PIPE_DEPTH + 1);

  localparam logic [AW-1:0]  PTR_ONE    = AW'(1);
  localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0]  CNT_FULL   = CW'(DEPTH);
  localparam logic [CW-1:0]  STALL_TH   = CW'(DEPTH - SKID);
  localparam logic [DRW-1:0] DRAIN_LOAD = DRW'(PIPE_DEPTH);
  localparam logic [DRW-1:0] DRAIN_ONE  = DRW'(1);
  localparam logic [DRW-1:0] DRAIN_ZERO = DRW'(0);

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_stall;
  logic [DRW-1:0]    r_drain_cnt;
  logic              r_overflow;

  logic              w_draining;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_push_ok;
  logic              w_drop;
  logic              w_mem_we;
  logic [CW-1:0]     w_count_next;
  logic [DATA_W-1:0] w_rd_data;

  // Handshake decode and next occupancy; a full FIFO still accepts when it pops in the same cycle.
  always_comb begin
    w_draining   = (r_drain_cnt != DRAIN_ZERO);
    w_push       = i_pipe_valid & ~w_draining;
    w_pop        = o_m_valid & i_m_ready;
    w_full       = (r_count == CNT_FULL);
    w_push_ok    = w_push & (~w_full | w_pop);
    w_drop       = w_push & w_full & ~w_pop;
    w_mem_we     = w_push_ok & ~i_flush & ~i_reset;
    w_count_next = r_count;
    if (w_push_ok && !w_pop) begin
      w_count_next = r_count + CNT_ONE;
    end else if (w_pop && !w_push_ok) begin
      w_count_next = r_count - CNT_ONE;
    end else begin
      w_count_next = r_count;
    end
  end

  // Pointer, occupancy, stall, drain and overflow state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= CNT_ZERO;
      r_stall     <= 1'b0;
      r_drain_cnt <= DRAIN_ZERO;
      r_overflow  <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= CNT_ZERO;
      r_stall     <= 1'b0;
      r_drain_cnt <= DRAIN_LOAD;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count <= w_count_next;
      r_stall <= (w_count_next >= STALL_TH);
      if (w_draining) begin
        r_drain_cnt <= r_drain_cnt - DRAIN_ONE;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  result_fifo_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk    (i_clk),
    .i_we     (w_mem_we),
    .i_wr_addr(r_wr_ptr),
    .i_wr_data(i_pipe_data),
    .i_rd_addr(r_rd_ptr),
    .o_rd_data(w_rd_data)
  );

  assign o_m_data   = w_rd_data;
  assign o_m_valid  = (r_count != CNT_ZERO);
  assign o_count    = r_count;
  assign o_stall    = r_stall;
  assign o_overflow = r_overflow;

`ifdef PIPELINE_COLLECTOR_STATS_EN
  logic [31:0] r_stat_accepted;
  logic [15:0] r_stat_dropped;
  logic [31:0] r_stat_stall_cycles;
  logic        w_drop_evt;

  // Results lost to a full FIFO, a flush, or the post-flush drain window all count as dropped.
  assign w_drop_evt = i_pipe_valid & (w_draining | i_flush | (w_full & ~w_pop));

  // Statistics counters; they wrap and survive flush.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stat_accepted     <= 32'd0;
      r_stat_dropped      <= 16'd0;
      r_stat_stall_cycles <= 32'd0;
    end else begin
      if (w_push_ok && !i_flush) begin
        r_stat_accepted <= r_stat_accepted + 32'd1;
      end
      if (w_drop_evt) begin
        r_stat_dropped <= r_stat_dropped + 16'd1;
      end
      if (r_stall) begin
        r_stat_stall_cycles <= r_stat_stall_cycles + 32'd1;
      end
    end
  end

  assign o_stat_accepted     = r_stat_accepted;
  assign o_stat_dropped      = r_stat_dropped;
  assign o_stat_stall_cycles = r_stat_stall_cycles;
`endif

endmodule

// File: tb/tb_pipeline_result_collector.sv
// Directed table-driven bench for pipeline_result_collector (DEPTH=8, PIPE_DEPTH=3),
// with hand-written sequences for full/overflow corner cases.
module tb_pipeline_result_collector;
  import pipeline_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      pipe_data;
  logic             pipe_valid;
  logic             flush;
  logic             stall;
  logic [31:0]      m_data;
  logic             m_valid;
  logic             m_ready;
  logic [CNT_W-1:0] count;
  logic             overflow;
`ifdef PIPELINE_COLLECTOR_STATS_EN
  logic [31:0]      stat_accepted;
  logic [15:0]      stat_dropped;
  logic [31:0]      stat_stall_cycles;
`endif

  always #5 clk = ~clk;

  pipeline_result_collector #(
    .DATA_W    (32),
    .DEPTH     (8),
    .PIPE_DEPTH(3)
  ) dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_pipe_data        (pipe_data),
    .i_pipe_valid       (pipe_valid),
    .i_flush            (flush),
    .o_stall            (stall),
    .o_m_data           (m_data),
    .o_m_valid          (m_valid),
    .i_m_ready          (m_ready),
    .o_count            (count),
`ifdef PIPELINE_COLLECTOR_STATS_EN
    .o_stat_accepted    (stat_accepted),
    .o_stat_dropped     (stat_dropped),
    .o_stat_stall_cycles(stat_stall_cycles),
`endif
    .o_overflow         (overflow)
  );

  typedef struct {
    logic        rst;
    logic        pv;
    logic [31:0] pd;
    logic        fl;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  ec;
    logic        es;
    logic        eo;
  } vec_t;

  vec_t tbl[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(input logic rst, input logic pv, input logic [31:0] pd,
                              input logic fl, input logic rdy, input logic ev,
                              input logic [31:0] ed, input logic [3:0] ec,
                              input logic es, input logic eo);
    vec_t v;
    v.rst = rst; v.pv = pv; v.pd = pd; v.fl = fl; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.ec = ec; v.es = es; v.eo = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic pv, input logic [31:0] pd,
                       input logic fl, input logic rdy);
    reset = rst; pipe_valid = pv; pipe_data = pd; flush = fl; m_ready = rdy;
  endtask

  task automatic check_state(input string tag, input logic ev, input logic [31:0] ed,
                             input logic [3:0] ec, input logic es, input logic eo);
    chk({tag, "_count"}, 32'(count), 32'(ec));
    chk({tag, "_m_valid"}, 32'(m_valid), 32'(ev));
    chk({tag, "_stall"}, 32'(stall), 32'(es));
    chk({tag, "_overflow"}, 32'(overflow), 32'(eo));
    if (ev) begin
      chk({tag, "_m_data"}, m_data, ed);
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);

    // reset, single pass-through
    tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b1, 32'hA5A5_0001, 4'd1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 1'b0, 1'b0));
    // fill with m_ready low: stall from count_next=4 onward
    for (int i = 1; i <= 8; i++) begin
      tbl.push_back(mk(1'b0, 1'b1, 32'h10 + 32'(i), 1'b0, 1'b0, 1'b1, 32'h11,
                       4'(i), (i >= 4) ? 1'b1 : 1'b0, 1'b0));
    end
    // two-cycle reset mid-traffic
    tbl.push_back(mk(1'b1, 1'b1, 32'h19,        1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 32'h1A,        1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 1'b0, 1'b0));
    // 5 buffered, flush, 3 drained off, 4th accepted
    for (int i = 1; i <= 5; i++) begin
      tbl.push_back(mk(1'b0, 1'b1, 32'h20 + 32'(i), 1'b0, 1'b0, 1'b1, 32'h21,
                       4'(i), (i >= 4) ? 1'b1 : 1'b0, 1'b0));
    end
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h31,        1'b0, 1'b0, 1'b0, 32'h0,         4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h32,        1'b0, 1'b0, 1'b0, 32'h0,         4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h33,        1'b0, 1'b0, 1'b0, 32'h0,         4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h34,        1'b0, 1'b0, 1'b1, 32'h34,        4'd1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 1'b0, 1'b0));
    // flush during drain reloads the drain window
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h41,        1'b0, 1'b0, 1'b0, 32'h0,         4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h42,        1'b1, 1'b0, 1'b0, 32'h0,         4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h43,        1'b0, 1'b0, 1'b0, 32'h0,         4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h44,        1'b0, 1'b0, 1'b0, 32'h0,         4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h45,        1'b0, 1'b0, 1'b0, 32'h0,         4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h46,        1'b0, 1'b0, 1'b1, 32'h46,        4'd1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 1'b0, 1'b0));
    // reset mid-drain clears the drain window
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h51,        1'b0, 1'b0, 1'b1, 32'h51,        4'd1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 1'b0, 1'b0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].pv, tbl[i].pd, tbl[i].fl, tbl[i].rdy);
      step();
      check_state($sformatf("v%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].es, tbl[i].eo);
    end

    // full, push+pop same cycle, then drain in order 1..9
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    step();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, 32'(i), 1'b0, 1'b0);
      step();
    end
    check_state("full8", 1'b1, 32'd1, 4'd8, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 32'd9, 1'b0, 1'b1);
    step();
    check_state("full_pushpop", 1'b1, 32'd2, 4'd8, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    for (int k = 2; k <= 9; k++) begin
      chk($sformatf("order_%0d", k), m_data, 32'(k));
      step();
      chk($sformatf("order_cnt_%0d", k), 32'(count), 32'(9 - k));
      chk($sformatf("order_stall_%0d", k), 32'(stall), (9 - k >= 4) ? 32'd1 : 32'd0);
    end

    // overflow: full, ignore stall, push with no pop
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    step();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, 32'h60 + 32'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step();
    check_state("drop", 1'b1, 32'h61, 4'd8, 1'b1, 1'b1);
`ifdef PIPELINE_COLLECTOR_STATS_EN
    chk("stat_dropped", 32'(stat_dropped), 32'd1);
    chk("stat_accepted", stat_accepted, 32'd8);
`endif
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drop_order_%0d", k), m_data, 32'h60 + 32'(k));
      step();
    end
    check_state("drop_empty", 1'b0, 32'd0, 4'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step();
    check_state("ovf_after_flush", 1'b0, 32'd0, 4'd0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    step();
    check_state("ovf_after_reset", 1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
